// File: rtl/branch_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : branch_ctrl_pkg
// Brief    : Shared types, opcodes and state encoding for branch resolution.
// Revision : 1.0
// ----------------------------------------------------------------------------
package branch_ctrl_pkg;

  typedef logic [3:0]  oper_t;
  typedef logic [31:0] word_t;

  localparam oper_t OP_NOP  = 4'd0;
  localparam oper_t OP_BEQ  = 4'd1;
  localparam oper_t OP_BNE  = 4'd2;
  localparam oper_t OP_BLT  = 4'd3;
  localparam oper_t OP_BGE  = 4'd4;
  localparam oper_t OP_BLTU = 4'd5;
  localparam oper_t OP_BGEU = 4'd6;

  localparam int BR_STATE_W = 2;

  typedef enum logic [BR_STATE_W-1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_OPND = 2'd1,
    ST_RESOLVE   = 2'd2,
    ST_REDIRECT  = 2'd3
  } br_state_e;

endpackage
`default_nettype wire

// File: rtl/branch_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : branch_ctrl_if
// Brief    : Dispatch, operand, fetch-redirect and status bundle of branch_ctrl.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface branch_ctrl_if #(
  parameter int CNT_W = 32
);
  import branch_ctrl_pkg::*;

  logic             br_valid;
  logic             br_ready;
  oper_t            br_op;
  word_t            br_pc;
  word_t            br_imm;
  word_t            opx;
  word_t            opy;
  logic             opx_ready;
  logic             opy_ready;
  logic             stall_req;
  logic             redirect_valid;
  word_t            redirect_pc;
  logic             fetch_ready;
  logic             flush;
  logic             exc_misalign;
  logic             exc_illegal;
  logic [CNT_W-1:0] cnt_resolved;
  logic [CNT_W-1:0] cnt_taken;

  // master: dispatch/forwarding/fetch side; slave: the controller
  modport master (
    output br_valid, br_op, br_pc, br_imm, opx, opy, opx_ready, opy_ready,
           fetch_ready,
    input  br_ready, stall_req, redirect_valid, redirect_pc, flush,
           exc_misalign, exc_illegal, cnt_resolved, cnt_taken
  );

  modport slave (
    input  br_valid, br_op, br_pc, br_imm, opx, opy, opx_ready, opy_ready,
           fetch_ready,
    output br_ready, stall_req, redirect_valid, redirect_pc, flush,
           exc_misalign, exc_illegal, cnt_resolved, cnt_taken
  );

endinterface
`default_nettype wire

// File: rtl/branch_ctrl_cmp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : branch_cmp
// Brief    : Combinational branch condition evaluation and opcode legality.
// Revision : 1.0
// ----------------------------------------------------------------------------
module branch_cmp
  import branch_ctrl_pkg::*;
(
  input  oper_t op_i,
  input  word_t x_i,
  input  word_t y_i,
  output logic  taken_o,
  output logic  illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (op_i)
      OP_BEQ:  taken_o = (x_i == y_i);
      OP_BNE:  taken_o = (x_i != y_i);
      OP_BLT:  taken_o = ($signed(x_i) <  $signed(y_i));
      OP_BGE:  taken_o = ($signed(x_i) >= $signed(y_i));
      OP_BLTU: taken_o = (x_i <  y_i);
      OP_BGEU: taken_o = (x_i >= y_i);
      default: illegal_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : branch_ctrl
// Brief    : Conditional-branch sequencer: operand capture, resolve, redirect.
// Revision : 1.0
// ----------------------------------------------------------------------------
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int INST_ALIGN = 2
) (
  input  wire logic    clk,
  input  wire logic    rst,
  branch_ctrl_if.slave bus
);

  localparam word_t ALIGN_MASK = (word_t'(1) << INST_ALIGN) - word_t'(1);

  br_state_e        state_q, state_d;
  oper_t            op_q, op_d;
  word_t            pc_q, pc_d;
  word_t            imm_q, imm_d;
  word_t            x_q, x_d;
  word_t            y_q, y_d;
  logic             xv_q, xv_d;
  logic             yv_q, yv_d;
  word_t            rpc_q, rpc_d;
  logic             flush_q, flush_d;
  logic             mis_q, mis_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] res_q, res_d;
  logic [CNT_W-1:0] tkn_q, tkn_d;

  logic  cmp_taken;
  logic  cmp_illegal;
  word_t target;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  branch_cmp u_cmp (
    .op_i      (op_q),
    .x_i       (x_q),
    .y_i       (y_q),
    .taken_o   (cmp_taken),
    .illegal_o (cmp_illegal)
  );

  assign target = pc_q + imm_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    x_d     = x_q;
    y_d     = y_q;
    xv_d    = xv_q;
    yv_d    = yv_q;
    rpc_d   = rpc_q;
    flush_d = 1'b0;
    mis_d   = 1'b0;
    ill_d   = 1'b0;
    res_d   = res_q;
    tkn_d   = tkn_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.br_valid) begin
          op_d  = bus.br_op;
          pc_d  = bus.br_pc;
          imm_d = bus.br_imm;
          xv_d  = bus.opx_ready;
          yv_d  = bus.opy_ready;
          if (bus.opx_ready) x_d = bus.opx;
          if (bus.opy_ready) y_d = bus.opy;
          state_d = (xv_d && yv_d) ? ST_RESOLVE : ST_WAIT_OPND;
        end
      end
      ST_WAIT_OPND: begin
        // A captured operand is frozen; later forwarding traffic is ignored.
        if (!xv_q && bus.opx_ready) begin
          x_d  = bus.opx;
          xv_d = 1'b1;
        end
        if (!yv_q && bus.opy_ready) begin
          y_d  = bus.opy;
          yv_d = 1'b1;
        end
        if (xv_d && yv_d) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        state_d = ST_IDLE;
        if (cmp_illegal) begin
          ill_d = 1'b1;
        end else begin
          res_d = sat_inc(res_q);
          if (cmp_taken) begin
            tkn_d = sat_inc(tkn_q);
            if ((target & ALIGN_MASK) != '0) begin
              mis_d = 1'b1;
            end else begin
              rpc_d   = target;
              flush_d = 1'b1;
              state_d = ST_REDIRECT;
            end
          end
        end
      end
      ST_REDIRECT: begin
        if (bus.fetch_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      pc_q    <= '0;
      imm_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      xv_q    <= 1'b0;
      yv_q    <= 1'b0;
      rpc_q   <= '0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      res_q   <= '0;
      tkn_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xv_q    <= xv_d;
      yv_q    <= yv_d;
      rpc_q   <= rpc_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
      res_q   <= res_d;
      tkn_q   <= tkn_d;
    end
  end

  assign bus.br_ready       = (state_q == ST_IDLE);
  assign bus.stall_req      = (state_q != ST_IDLE);
  assign bus.redirect_valid = (state_q == ST_REDIRECT);
  assign bus.redirect_pc    = rpc_q;
  assign bus.flush          = flush_q;
  assign bus.exc_misalign   = mis_q;
  assign bus.exc_illegal    = ill_q;
  assign bus.cnt_resolved   = res_q;
  assign bus.cnt_taken      = tkn_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_branch_ctrl
// Brief    : Scoreboard bench for branch_ctrl with a behavioural reference model.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  localparam int  SCNT_W = 3;
  localparam longint SMAX = (1 << SCNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_ctrl_if #(.CNT_W(32))     bus  ();
  branch_ctrl_if #(.CNT_W(SCNT_W)) sbus ();

  branch_ctrl #(.CNT_W(32), .INST_ALIGN(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Narrow-counter twin sees identical stimulus; used for saturation checks.
  branch_ctrl #(.CNT_W(SCNT_W), .INST_ALIGN(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus.slave)
  );

  assign sbus.br_valid    = bus.br_valid;
  assign sbus.br_op       = bus.br_op;
  assign sbus.br_pc       = bus.br_pc;
  assign sbus.br_imm      = bus.br_imm;
  assign sbus.opx         = bus.opx;
  assign sbus.opy         = bus.opy;
  assign sbus.opx_ready   = bus.opx_ready;
  assign sbus.opy_ready   = bus.opy_ready;
  assign sbus.fetch_ready = bus.fetch_ready;

  // kind: 0 not taken, 1 redirect, 2 misaligned, 3 illegal
  typedef struct {
    int     kind;
    word_t  pc;
    int     stall_cyc;
    int     rv_cyc;
    longint res;
    longint tkn;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  longint m_res  = 0;
  longint m_tkn  = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic longint smin(input longint v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int    busy_cyc, rv_cyc, fl_cyc;
    bit    pc_changed, exc_busy, prev_stall;
    word_t first_pc;
    exp_t  e;
    busy_cyc = 0; rv_cyc = 0; fl_cyc = 0;
    pc_changed = 0; exc_busy = 0; prev_stall = 0; first_pc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cyc = 0; rv_cyc = 0; fl_cyc = 0;
        pc_changed = 0; exc_busy = 0; prev_stall = 0;
      end else begin
        if (bus.stall_req) begin
          busy_cyc++;
          if (bus.redirect_valid) begin
            if (rv_cyc == 0) first_pc = bus.redirect_pc;
            else if (bus.redirect_pc != first_pc) pc_changed = 1;
            rv_cyc++;
          end
          if (bus.flush) fl_cyc++;
          if (bus.exc_misalign || bus.exc_illegal) exc_busy = 1;
        end else if (prev_stall) begin
          if (exp_q.size() == 0) begin
            check("orphan_completion", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("redirect_seen", longint'(rv_cyc != 0), longint'(e.kind == 1));
            check("redirect_cycles", rv_cyc, e.rv_cyc);
            if (e.kind == 1) begin
              check("redirect_pc", first_pc, e.pc);
              check("redirect_pc_stable", pc_changed, 0);
            end
            check("flush_cycles", fl_cyc, (e.kind == 1) ? 1 : 0);
            check("exc_misalign", bus.exc_misalign, longint'(e.kind == 2));
            check("exc_illegal", bus.exc_illegal, longint'(e.kind == 3));
            check("exc_while_busy", exc_busy, 0);
            check("stall_cycles", busy_cyc, e.stall_cyc);
            check("cnt_resolved", bus.cnt_resolved, e.res);
            check("cnt_taken", bus.cnt_taken, e.tkn);
            check("sat_cnt_resolved", sbus.cnt_resolved, smin(e.res));
            check("sat_cnt_taken", sbus.cnt_taken, smin(e.tkn));
          end
          busy_cyc = 0; rv_cyc = 0; fl_cyc = 0;
          pc_changed = 0; exc_busy = 0;
        end else begin
          check("idle_quiet",
                {bus.exc_misalign, bus.exc_illegal, bus.flush, bus.redirect_valid}, 0);
        end
        prev_stall = bus.stall_req;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int model_kind(input oper_t op, input word_t x, input word_t y,
                                    input word_t pc, input word_t imm);
    bit    taken;
    word_t t;
    t = pc + imm;
    case (op)
      OP_BEQ:  taken = (x == y);
      OP_BNE:  taken = (x != y);
      OP_BLT:  taken = ($signed(x) < $signed(y));
      OP_BGE:  taken = !($signed(x) < $signed(y));
      OP_BLTU: taken = (x < y);
      OP_BGEU: taken = !(x < y);
      default: return 3;
    endcase
    if (!taken) return 0;
    return (t % 4 != 0) ? 2 : 1;
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive_noise();
    bus.br_valid = bus.stall_req ? 1'($urandom % 2) : 1'b0;
    bus.br_op    = oper_t'($urandom);
    bus.br_pc    = $urandom;
    bus.br_imm   = $urandom;
  endtask

  task automatic issue(input oper_t op, input word_t pc, input word_t imm,
                       input word_t x, input word_t y,
                       input int dx, input int dy, input int nlow);
    exp_t e;
    int   n, mx;
    n = 0;
    while (!bus.br_ready && n < 200) begin
      drive_noise();
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("timeout_idle", 0, 1);
    mx          = (dx > dy) ? dx : dy;
    e.kind      = model_kind(op, x, y, pc, imm);
    e.pc        = pc + imm;
    e.rv_cyc    = (e.kind == 1) ? nlow + 1 : 0;
    e.stall_cyc = mx + 1 + e.rv_cyc;
    if (e.kind != 3) m_res++;
    if (e.kind == 1 || e.kind == 2) m_tkn++;
    e.res = m_res;
    e.tkn = m_tkn;
    exp_q.push_back(e);

    bus.br_valid    = 1'b1;
    bus.br_op       = op;
    bus.br_pc       = pc;
    bus.br_imm      = imm;
    bus.opx_ready   = (dx == 0);
    bus.opy_ready   = (dy == 0);
    bus.opx         = (dx == 0) ? x : $urandom;
    bus.opy         = (dy == 0) ? y : $urandom;
    bus.fetch_ready = (nlow == 0);
    @(posedge clk); #1;
    for (int k = 1; k <= mx; k++) begin
      drive_noise();
      bus.opx_ready = (k == dx) ? 1'b1 : (k > dx) ? 1'($urandom % 2) : 1'b0;
      bus.opy_ready = (k == dy) ? 1'b1 : (k > dy) ? 1'($urandom % 2) : 1'b0;
      bus.opx       = (k == dx) ? x : $urandom;
      bus.opy       = (k == dy) ? y : $urandom;
      @(posedge clk); #1;
    end
    bus.opx_ready = 1'($urandom % 2);
    bus.opy_ready = 1'($urandom % 2);
    bus.opx       = $urandom;
    bus.opy       = $urandom;
    if (e.kind == 1) begin
      n = 0;
      while (!bus.redirect_valid && n < 50) begin
        drive_noise();
        @(posedge clk); #1;
        n++;
      end
      if (n >= 50) check("timeout_redirect", 0, 1);
      repeat (nlow) begin
        drive_noise();
        @(posedge clk); #1;
      end
      bus.fetch_ready = 1'b1;
    end
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_br_ready"}, bus.br_ready, 1);
    check({tag, "_stall_req"}, bus.stall_req, 0);
    check({tag, "_redirect_valid"}, bus.redirect_valid, 0);
    check({tag, "_flush"}, bus.flush, 0);
    check({tag, "_exc"}, {bus.exc_misalign, bus.exc_illegal}, 0);
    check({tag, "_cnt_resolved"}, bus.cnt_resolved, 0);
    check({tag, "_cnt_taken"}, bus.cnt_taken, 0);
  endtask

  initial begin
    oper_t op;
    word_t x, y, pc, imm;
    int    sel, n;
    rst = 1'b1;
    bus.br_valid = 0; bus.br_op = OP_NOP; bus.br_pc = 0; bus.br_imm = 0;
    bus.opx = 0; bus.opy = 0; bus.opx_ready = 0; bus.opy_ready = 0;
    bus.fetch_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    reset_check("reset");
    rst = 1'b0;

    issue(OP_BEQ,  32'h100, 32'h20, 32'h5, 32'h5, 0, 0, 0);
    issue(OP_BLT,  32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 0, 0, 0);
    issue(OP_BLTU, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 0, 0, 0);
    issue(OP_BNE,  32'h300, 32'hFFFF_FFF0, 32'h7, 32'h9, 0, 3, 0);
    issue(OP_BNE,  32'h300, 32'h10, 32'h7, 32'h7, 2, 1, 0);
    issue(OP_BGE,  32'h100, 32'h2, 32'h3, 32'h3, 0, 0, 0);
    issue(OP_BGEU, 32'h400, 32'h8, 32'h9, 32'h2, 1, 0, 4);
    issue(OP_NOP,  32'h500, 32'h8, 32'h1, 32'h1, 0, 0, 0);
    issue(oper_t'(4'hF), 32'h500, 32'h8, 32'h1, 32'h2, 0, 1, 0);
    issue(OP_BEQ,  32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0, 0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      op  = (sel == 0) ? oper_t'($urandom_range(7, 15)) : oper_t'($urandom_range(1, 6));
      x   = $urandom;
      sel = $urandom_range(0, 2);
      y   = (sel == 0) ? x : (sel == 1) ? word_t'($urandom) : x + 32'd1;
      pc  = word_t'($urandom) & 32'hFFFF_FFFC;
      imm = word_t'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 4) == 0) imm = imm | 32'h2;
      if ($urandom_range(0, 1) == 1) imm = -imm;
      issue(op, pc, imm, x, y, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3));
    end

    // Abort a branch while it is holding a redirect.
    n = 0;
    while (!bus.br_ready && n < 200) begin
      drive_noise();
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("timeout_idle", 0, 1);
    bus.br_valid = 1; bus.br_op = OP_BEQ; bus.br_pc = 32'h800; bus.br_imm = 32'h40;
    bus.opx = 32'h1; bus.opy = 32'h1; bus.opx_ready = 1; bus.opy_ready = 1;
    bus.fetch_ready = 0;
    @(posedge clk); #1;
    bus.br_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_in_redirect", bus.redirect_valid, 1);
    rst = 1'b1;
    exp_q.delete();
    m_res = 0;
    m_tkn = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    reset_check("abort");
    check("abort_sat_cnt", {sbus.cnt_resolved, sbus.cnt_taken}, 0);
    @(posedge clk); #1;
    check("abort_no_redirect", {bus.redirect_valid, bus.flush}, 0);
    bus.fetch_ready = 1;

    issue(OP_BEQ, 32'h100, 32'h20, 32'h5, 32'h5, 0, 0, 0);
    issue(OP_NOP, 32'h100, 32'h20, 32'h5, 32'h5, 0, 0, 0);
    n = 0;
    while (!bus.br_ready && n < 200) begin
      drive_noise();
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("timeout_idle", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("drain_scoreboard", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
